whackamole_game: RTL and testbench
==================================

# whackamole_game

Game core for the whack-a-mole design: it produces the mole position, hit/miss feedback flags and two-digit BCD score that `vga_display` consumes. It runs on `master_clk` in the board top level, takes hole inputs from the board switches and replaces the constant tie-offs currently driving the display's game inputs. Mole placement comes from a free-running LFSR, and each mole's lifetime and feedback duration are counted in clock cycles.

## Interface
- `MOLE_TICKS`, default 100_000_000: maximum number of cycles a mole stays up.
- `FEEDBACK_TICKS`, default 50_000_000: number of cycles a feedback flag is held.
- `LFSR_SEED`, default 8'hA5: reset value of the LFSR. Must be non-zero.
- `master_clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `hit` input, 8 bits: level hole inputs, one per hole, already debounced.
- `mole_position` output, 3 bits: index of the active hole.
- `guess_correct` output, 1 bit: high while the feedback window for a correct hit is active.
- `guess_wrong` output, 1 bit: high while the feedback window for a wrong hit or timeout is active.
- `digit_1` output, 4 bits: BCD tens digit of the score.
- `digit_2` output, 4 bits: BCD ones digit of the score.

## Operation
- Reset values:
  - `mole_position` = 0, `guess_correct` = 0, `guess_wrong` = 0, `digit_1` = 0, `digit_2` = 0.
  - LFSR = `LFSR_SEED`, state = SPAWN, tick counter = 0.
  - Edge register loads the current `hit` value, so a switch held through reset produces no edge.
- Edge detect: `rise = hit & ~hit_q`, where `hit_q` registers `hit` every cycle.
- LFSR: advances every cycle, including during FEEDBACK. Update is `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
- FSM states: SPAWN, UP, FEEDBACK.
- SPAWN, 1 cycle:
  - Candidate position is `lfsr[2:0]`.
  - If the candidate equals the current `mole_position`, load `(candidate+1) mod 8`; otherwise load the candidate.
  - Clear the counter and go to UP.
- UP:
  - Counter increments each cycle.
  - Any `rise` bit other than `mole_position` → `guess_wrong` <= 1, go to FEEDBACK. Wrong takes priority over a simultaneous correct bit.
  - Otherwise `rise[mole_position]` → `guess_correct` <= 1, score +1, go to FEEDBACK.
  - Otherwise, when counter = `MOLE_TICKS-1` → timeout, `guess_wrong` <= 1, go to FEEDBACK.
  - Clear the counter on every exit.
- FEEDBACK:
  - `rise` is ignored.
  - When counter = `FEEDBACK_TICKS-1`, clear both flags and go to SPAWN.
- Score arithmetic:
  - Two-digit BCD increment: if `digit_2` = 9, set it to 0 and carry into `digit_1`.
  - Saturates at 99; an increment at 99 leaves 99.
- At most one of `guess_correct` / `guess_wrong` is ever high.
- `mole_position` changes only in SPAWN.

## Timing
- A `hit` rising edge sampled at cycle N in UP drives the flag high and updates the score from cycle N+1.
- A flag stays high for exactly `FEEDBACK_TICKS` cycles.
- After the flag drops, the new `mole_position` appears 1 cycle later.
- A timed-out mole is up for exactly `MOLE_TICKS` cycles before `guess_wrong` asserts.
- The first mole after reset deasserts appears on the second cycle: SPAWN occupies the first.
- Reset mid-operation (any state) forces all reset values on the next edge. No partial feedback or score survives.

## Configuration
- `WHACKAMOLE_MISS_PENALTY_EN`
  - Defined: each wrong hit or timeout decrements the BCD score. Borrow goes from `digit_1` when `digit_2` = 0, and the score saturates at 00.
  - Undefined: wrong hits and timeouts leave the score unchanged.

## Test plan
Use `MOLE_TICKS`=20, `FEEDBACK_TICKS`=5.
- Reset behaviour: hold `hit`=8'hFF through reset, then release `rst` → no flag asserts. After SPAWN, `mole_position` equals the bench LFSR model's value with the duplicate-skip rule applied, and the digits read 0/0.
- Correct hit: raise `hit[mole_position]` in UP → `guess_correct`=1 for exactly 5 cycles, `digit_2`=1, and the next mole differs from the previous one.
- Wrong hit, including simultaneous correct + wrong: raise `hit` with bits {mole, other} set in the same cycle → `guess_wrong`=1 for 5 cycles, score unchanged. With `WHACKAMOLE_MISS_PENALTY_EN` defined, a score of 10 becomes 09.
- Timeout: no `hit` edges → `guess_wrong` rises exactly 20 cycles after `mole_position` updates.
- BCD carry and saturation: 9 correct hits → score 0/9, tenth hit → 1/0. 100 hits → 9/9, one more hit → 9/9.
- Reset during FEEDBACK with score 0/3 → next cycle flags are 0, digits 0/0, `mole_position`=0.

Source files
------------

// File: rtl/whackamole_game.sv
// Whack-a-mole game core: LFSR mole placement, hit/miss feedback flags and a saturating BCD score.
// Define WHACKAMOLE_MISS_PENALTY_EN to make wrong hits and timeouts decrement the score.
module whackamole_game #(
    parameter int unsigned MOLE_TICKS     = 100_000_000,
    parameter int unsigned FEEDBACK_TICKS = 50_000_000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic [7:0] hit,
    output logic [2:0] mole_position,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2
);
    typedef enum logic [1:0] {SPAWN, UP, FEEDBACK} state_t;

    localparam logic [31:0] MOLE_LAST = 32'(MOLE_TICKS - 1);
    localparam logic [31:0] FB_LAST   = 32'(FEEDBACK_TICKS - 1);

    state_t      state_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  hit_q;
    logic [31:0] cnt_q;
    logic [2:0]  pos_q;
    logic        correct_q;
    logic        wrong_q;
    logic [3:0]  tens_q;
    logic [3:0]  ones_q;

    logic [7:0]  rise;
    logic        wrong_hit;
    logic        correct_hit;
    logic        timeout;
    logic [2:0]  cand;
    logic [2:0]  spawn_pos;
    logic [3:0]  tens_inc;
    logic [3:0]  ones_inc;
    logic [3:0]  tens_miss;
    logic [3:0]  ones_miss;

    assign rise        = hit & ~hit_q;
    assign wrong_hit   = |(rise & ~(8'd1 << pos_q));
    assign correct_hit = rise[pos_q];
    assign timeout     = (cnt_q == MOLE_LAST);
    assign cand        = lfsr_q[2:0];
    // Never respawn in the same hole: bump a repeated candidate to the next one.
    assign spawn_pos   = (cand == pos_q) ? cand + 3'd1 : cand;

    always_comb begin
        tens_inc = tens_q;
        ones_inc = ones_q;
        if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_inc = 4'd0;
                tens_inc = tens_q + 4'd1;
            end else begin
                ones_inc = ones_q + 4'd1;
            end
        end
    end

`ifdef WHACKAMOLE_MISS_PENALTY_EN
    always_comb begin
        tens_miss = tens_q;
        ones_miss = ones_q;
        if (!(tens_q == 4'd0 && ones_q == 4'd0)) begin
            if (ones_q == 4'd0) begin
                ones_miss = 4'd9;
                tens_miss = tens_q - 4'd1;
            end else begin
                ones_miss = ones_q - 4'd1;
            end
        end
    end
`else
    assign tens_miss = tens_q;
    assign ones_miss = ones_q;
`endif

    always_ff @(posedge master_clk) begin
        if (rst) begin
            state_q   <= SPAWN;
            lfsr_q    <= LFSR_SEED;
            hit_q     <= hit;
            cnt_q     <= '0;
            pos_q     <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            hit_q  <= hit;
            case (state_q)
                SPAWN: begin
                    pos_q   <= spawn_pos;
                    cnt_q   <= '0;
                    state_q <= UP;
                end
                UP: begin
                    cnt_q <= cnt_q + 32'd1;
                    // A stray hole beats the mole's own hole when both rise together.
                    if (wrong_hit || (!correct_hit && timeout)) begin
                        wrong_q <= 1'b1;
                        tens_q  <= tens_miss;
                        ones_q  <= ones_miss;
                        cnt_q   <= '0;
                        state_q <= FEEDBACK;
                    end else if (correct_hit) begin
                        correct_q <= 1'b1;
                        tens_q    <= tens_inc;
                        ones_q    <= ones_inc;
                        cnt_q     <= '0;
                        state_q   <= FEEDBACK;
                    end
                end
                FEEDBACK: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (cnt_q == FB_LAST) begin
                        correct_q <= 1'b0;
                        wrong_q   <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= SPAWN;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= SPAWN;
                end
            endcase
        end
    end

    assign mole_position = pos_q;
    assign guess_correct = correct_q;
    assign guess_wrong   = wrong_q;
    assign digit_1       = tens_q;
    assign digit_2       = ones_q;
endmodule

// File: tb/tb_whackamole_game.sv
// Directed bench for whackamole_game with short mole/feedback windows and an LFSR reference model.
module tb_whackamole_game;
    localparam int MT = 20;
    localparam int FT = 5;
    localparam logic [7:0] SEED = 8'hA5;

    logic       master_clk = 1'b0;
    logic       rst;
    logic [7:0] hit;
    logic [2:0] mole_position;
    logic       guess_correct;
    logic       guess_wrong;
    logic [3:0] digit_1;
    logic [3:0] digit_2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] lfsr_m;
    logic [2:0] exp_pos;
    int         exp_score;

    whackamole_game #(
        .MOLE_TICKS    (MT),
        .FEEDBACK_TICKS(FT),
        .LFSR_SEED     (SEED)
    ) dut (
        .master_clk   (master_clk),
        .rst          (rst),
        .hit          (hit),
        .mole_position(mole_position),
        .guess_correct(guess_correct),
        .guess_wrong  (guess_wrong),
        .digit_1      (digit_1),
        .digit_2      (digit_2)
    );

    // Clock and reference LFSR
    always #5 master_clk = ~master_clk;

    always @(posedge master_clk) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge master_clk);
    endtask

    function automatic int miss_score(input int s);
`ifdef WHACKAMOLE_MISS_PENALTY_EN
        return (s > 0) ? s - 1 : 0;
`else
        return s;
`endif
    endfunction

    task automatic check_score(input string tag);
        check({tag, "_tens"}, 32'(digit_1), 32'(exp_score / 10));
        check({tag, "_ones"}, 32'(digit_2), 32'(exp_score % 10));
    endtask

    // Called at the negedge of the SPAWN cycle; the next posedge places the mole.
    task automatic spawn_expect(input string tag);
        logic [2:0] cand;
        logic [2:0] prev;
        cand    = lfsr_m[2:0];
        prev    = exp_pos;
        exp_pos = (cand == prev) ? cand + 3'd1 : cand;
        tick();
        check({tag, "_pos"}, 32'(mole_position), 32'(exp_pos));
        check({tag, "_differs"}, 32'(mole_position != prev), 32'd1);
    endtask

    task automatic do_hit(input logic [7:0] mask);
        hit = mask;
        tick();
        hit = 8'h00;
    endtask

    // Entered at the negedge right after the flag-raising edge.
    task automatic feedback(input logic exp_correct, input string tag);
        int n_hi;
        int n_other;
        n_hi    = 0;
        n_other = 0;
        for (int i = 0; i < FT; i++) begin
            if (exp_correct ? guess_correct : guess_wrong) n_hi++;
            if (exp_correct ? guess_wrong : guess_correct) n_other++;
            tick();
        end
        check({tag, "_flag_cycles"}, 32'(n_hi), 32'(FT));
        check({tag, "_other_flag"}, 32'(n_other), 32'd0);
        check({tag, "_flags_clear"}, 32'({guess_correct, guess_wrong}), 32'd0);
    endtask

    task automatic correct_hit(input string tag);
        do_hit(8'd1 << exp_pos);
        exp_score = (exp_score < 99) ? exp_score + 1 : 99;
        check_score(tag);
        feedback(1'b1, tag);
        spawn_expect(tag);
    endtask

    task automatic wrong_hit(input logic [7:0] mask, input string tag);
        do_hit(mask);
        exp_score = miss_score(exp_score);
        check_score(tag);
        feedback(1'b0, tag);
        spawn_expect(tag);
    endtask

    initial begin
        logic [2:0] other;
        int k;
        int guard;

        rst       = 1'b1;
        hit       = 8'hFF;
        exp_pos   = 3'd0;
        exp_score = 0;
        repeat (3) tick();
        check("rst_pos", 32'(mole_position), 32'd0);
        check("rst_flags", 32'({guess_correct, guess_wrong}), 32'd0);
        check("rst_tens", 32'(digit_1), 32'd0);
        check("rst_ones", 32'(digit_2), 32'd0);

        rst = 1'b0;
        spawn_expect("first_spawn");
        check("first_spawn_seed", 32'(mole_position), 32'd5);
        check_score("first_spawn");

        // Switches held high through reset must not look like a fresh press.
        repeat (3) tick();
        check("held_no_flag", 32'({guess_correct, guess_wrong}), 32'd0);
        hit = 8'h00;
        tick();
        check("release_no_flag", 32'({guess_correct, guess_wrong}), 32'd0);

        correct_hit("hit1");
        check("hit1_ones", 32'(digit_2), 32'd1);
        for (int i = 2; i <= 9; i++) correct_hit($sformatf("hit%0d", i));
        check("nine_tens", 32'(digit_1), 32'd0);
        check("nine_ones", 32'(digit_2), 32'd9);
        correct_hit("hit10");
        check("ten_tens", 32'(digit_1), 32'd1);
        check("ten_ones", 32'(digit_2), 32'd0);

        other = exp_pos + 3'd4;
        wrong_hit((8'd1 << exp_pos) | (8'd1 << other), "both_bits");
`ifdef WHACKAMOLE_MISS_PENALTY_EN
        check("penalty_tens", 32'(digit_1), 32'd0);
        check("penalty_ones", 32'(digit_2), 32'd9);
`else
        check("nopenalty_tens", 32'(digit_1), 32'd1);
        check("nopenalty_ones", 32'(digit_2), 32'd0);
`endif
        other = exp_pos + 3'd1;
        wrong_hit(8'd1 << other, "wrong_only");

        k = 0;
        while (!guess_wrong && k < 2 * MT) begin
            tick();
            k++;
        end
        check("timeout_latency", 32'(k), 32'(MT));
        exp_score = miss_score(exp_score);
        check_score("timeout");
        feedback(1'b0, "timeout");
        spawn_expect("timeout");

        guard = 0;
        while (exp_score < 99 && guard < 150) begin
            correct_hit("fill");
            guard++;
        end
        check("full_tens", 32'(digit_1), 32'd9);
        check("full_ones", 32'(digit_2), 32'd9);
        correct_hit("sat");
        check("sat_tens", 32'(digit_1), 32'd9);
        check("sat_ones", 32'(digit_2), 32'd9);

        rst = 1'b1;
        tick();
        rst       = 1'b0;
        exp_pos   = 3'd0;
        exp_score = 0;
        check_score("rst2");
        spawn_expect("rst2");
        correct_hit("pre1");
        correct_hit("pre2");
        do_hit(8'd1 << exp_pos);
        exp_score = 3;
        check_score("pre3");
        check("pre3_flag", 32'(guess_correct), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("midfb_flags", 32'({guess_correct, guess_wrong}), 32'd0);
        check("midfb_tens", 32'(digit_1), 32'd0);
        check("midfb_ones", 32'(digit_2), 32'd0);
        check("midfb_pos", 32'(mole_position), 32'd0);
        rst       = 1'b0;
        exp_pos   = 3'd0;
        exp_score = 0;
        spawn_expect("after_midfb");
        check("after_midfb_seed", 32'(mole_position), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
